// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/halt controller for a single-cycle CPU.
// Two raw push buttons are synchronized and debounced into one-cycle
// pulses (go_p, step_p). A four-state FSM turns those pulses, the speed
// switch and the decoded halt request into a registered per-instruction
// write enable (cpu_en) and keeps a retired-instruction counter.

module cpu_run_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int SLOW_DIV   = 4000000
) (
    input  logic        clkN,
    input  logic        rst,
    input  logic        btn_go,
    input  logic        btn_step,
    input  logic        turn,
    input  logic        halt_in,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic        running,
    output logic [31:0] instr_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        STEP   = 2'b10,
        HALTED = 2'b11
    } state_t;

    // The pulse fires on the sample that takes the counter from
    // DEB_CYCLES-1 to DEB_CYCLES; the counter then parks at DEB_CYCLES
    // until a low sample, so a long hold cannot re-trigger.
    localparam logic [7:0]  DEB_LAST  = 8'(DEB_CYCLES - 1);
    localparam logic [7:0]  DEB_FULL  = 8'(DEB_CYCLES);
    localparam logic [25:0] SLOW_LAST = 26'(SLOW_DIV - 1);

    // Bit 0 is the go button, bit 1 is the step button.
    logic [1:0]  sync1_q;
    logic [1:0]  sync2_q;
    logic [1:0]  pulse_q;
    logic [7:0]  debCnt_q [2];
    logic        goP;
    logic        stepP;

    state_t      state_q;
    logic        cpuEn_q;
    logic        turn_q;
    logic [25:0] tickCnt_q;
    logic [25:0] tickCnt_d;
    logic [31:0] instrCnt_q;
    logic        turnChanged;
    logic        tick;

    assign goP   = pulse_q[0];
    assign stepP = pulse_q[1];

    // Synchronize and debounce both buttons; runs in every FSM state.
    always_ff @(posedge clkN) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            pulse_q     <= '0;
            debCnt_q[0] <= '0;
            debCnt_q[1] <= '0;
        end else begin
            sync1_q <= {btn_step, btn_go};
            sync2_q <= sync1_q;
            for (int b = 0; b < 2; b++) begin
                if (!sync2_q[b]) begin
                    debCnt_q[b] <= '0;
                    pulse_q[b]  <= 1'b0;
                end else begin
                    pulse_q[b] <= (debCnt_q[b] == DEB_LAST);
                    if (debCnt_q[b] != DEB_FULL) begin
                        debCnt_q[b] <= debCnt_q[b] + 8'd1;
                    end
                end
            end
        end
    end

    // Advance tick generation: every cycle in fast mode, every SLOW_DIV cycles in slow mode.
    always_comb begin
        turnChanged = (turn != turn_q);
        tick        = 1'b0;
        tickCnt_d   = tickCnt_q + 26'd1;
        if (turn) begin
            tick      = 1'b1;
            tickCnt_d = '0;
        end else if (turnChanged) begin
            tickCnt_d = '0;
        end else if (tickCnt_q == SLOW_LAST) begin
            tick      = 1'b1;
            tickCnt_d = '0;
        end
    end

    // Run-control FSM with registered enable and retired-instruction counter.
    always_ff @(posedge clkN) begin
        if (rst) begin
            state_q    <= IDLE;
            cpuEn_q    <= 1'b0;
            turn_q     <= 1'b0;
            tickCnt_q  <= '0;
            instrCnt_q <= '0;
        end else begin
            turn_q     <= turn;
            cpuEn_q    <= 1'b0;
            instrCnt_q <= instrCnt_q + {31'd0, cpuEn_q};
            case (state_q)
                IDLE: begin
                    tickCnt_q <= '0;
                    if (goP) begin
                        state_q <= RUN;
                    end else if (stepP) begin
                        state_q <= STEP;
                    end
                end
                STEP: begin
                    if (halt_in) begin
                        state_q <= HALTED;
                    end else begin
                        cpuEn_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (stepP) begin
                        tickCnt_q <= '0;
                        state_q   <= IDLE;
                    end else begin
                        tickCnt_q <= tickCnt_d;
                        if (tick) begin
                            if (halt_in) begin
                                state_q <= HALTED;
                            end else begin
                                cpuEn_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= HALTED;
                end
            endcase
        end
    end

    assign cpu_en    = cpuEn_q;
    assign state     = state_q;
    assign running   = (state_q == RUN);
    assign instr_cnt = instrCnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed test of the run/step/halt controller with
// DEB_CYCLES=4 and SLOW_DIV=4. Inputs change on the falling edge and
// outputs are read on the falling edge after each rising edge; the loop
// index k in each task counts rising edges after the first edge that
// samples a newly pressed button.

module tb_cpu_run_ctrl;

    logic        clkN = 1'b0;
    logic        rst;
    logic        btnGo;
    logic        btnStep;
    logic        turn;
    logic        haltIn;
    logic        cpuEn;
    logic [1:0]  state;
    logic        running;
    logic [31:0] instrCnt;

    int checks   = 0;
    int failures = 0;
    int unsigned expInstr = 0;

    always #5 clkN = ~clkN;

    cpu_run_ctrl #(
        .DEB_CYCLES(4),
        .SLOW_DIV  (4)
    ) dut (
        .clkN     (clkN),
        .rst      (rst),
        .btn_go   (btnGo),
        .btn_step (btnStep),
        .turn     (turn),
        .halt_in  (haltIn),
        .cpu_en   (cpuEn),
        .state    (state),
        .running  (running),
        .instr_cnt(instrCnt)
    );

    // One clock: pass a rising edge and stop on the following falling edge.
    task automatic nextCycle();
        @(posedge clkN);
        @(negedge clkN);
    endtask

    // Reset with all inputs idle; every output must be at its reset value.
    task automatic test_reset();
        rst = 1'b1; btnGo = 1'b0; btnStep = 1'b0; turn = 1'b0; haltIn = 1'b0;
        nextCycle();
        nextCycle();
        checks++; if (state !== 2'b00) begin failures++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        checks++; if (cpuEn !== 1'b0) begin failures++; $display("[TB] FAIL reset_cpu_en: got %0b expected 0", cpuEn); end
        checks++; if (running !== 1'b0) begin failures++; $display("[TB] FAIL reset_running: got %0b expected 0", running); end
        checks++; if (instrCnt !== 32'd0) begin failures++; $display("[TB] FAIL reset_instr_cnt: got %0h expected 0", instrCnt); end
        rst = 1'b0;
        expInstr = 0;
    endtask

    // Held step button: one pulse, STEP for one cycle, cpu_en 7 edges after first sample.
    task automatic test_step();
        int pulses = 0;
        int pulseAt = -1;
        btnStep = 1'b1;
        for (int k = 0; k <= 14; k++) begin
            nextCycle();
            if (k == 6) begin
                checks++; if (state !== 2'b10) begin failures++; $display("[TB] FAIL step_enter_state: got %0d expected 2", state); end
            end
            if (cpuEn === 1'b1) begin
                pulses++;
                pulseAt = k;
            end
            if (k == 9) btnStep = 1'b0;
        end
        checks++; if (pulses != 1) begin failures++; $display("[TB] FAIL step_pulse_count: got %0d expected 1", pulses); end
        checks++; if (pulseAt != 7) begin failures++; $display("[TB] FAIL step_pulse_latency: got %0d expected 7", pulseAt); end
        checks++; if (state !== 2'b00) begin failures++; $display("[TB] FAIL step_final_state: got %0d expected 0", state); end
        expInstr = 1;
        checks++; if (instrCnt !== expInstr) begin failures++; $display("[TB] FAIL step_instr_cnt: got %0d expected %0d", instrCnt, expInstr); end
    endtask

    // Bouncing go button never stays high long enough to qualify.
    task automatic test_bounce();
        int bad = 0;
        for (int k = 0; k < 20; k++) begin
            btnGo = (((k / 2) % 2) == 0);
            nextCycle();
            if (cpuEn !== 1'b0 || state !== 2'b00) bad++;
        end
        btnGo = 1'b0;
        for (int k = 0; k < 8; k++) begin
            nextCycle();
            if (cpuEn !== 1'b0 || state !== 2'b00) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL bounce_quiet: got %0d bad cycles expected 0", bad); end
        checks++; if (state !== 2'b00) begin failures++; $display("[TB] FAIL bounce_state: got %0d expected 0", state); end
        checks++; if (instrCnt !== expInstr) begin failures++; $display("[TB] FAIL bounce_instr_cnt: got %0d expected %0d", instrCnt, expInstr); end
    endtask

    // Slow run (enable every 4th cycle), then fast run (enable every cycle).
    task automatic test_run();
        logic expEn;
        turn = 1'b0;
        btnGo = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            nextCycle();
            if (k == 5) begin
                checks++; if (state !== 2'b00) begin failures++; $display("[TB] FAIL run_pre_entry: got %0d expected 0", state); end
            end
            if (k == 6) begin
                checks++; if (state !== 2'b01) begin failures++; $display("[TB] FAIL run_entry_state: got %0d expected 1", state); end
                checks++; if (running !== 1'b1) begin failures++; $display("[TB] FAIL run_running: got %0b expected 1", running); end
            end
            if (k >= 7) begin
                expEn = (((k - 6) % 4) == 0);
                checks++; if (cpuEn !== expEn) begin failures++; $display("[TB] FAIL run_slow_en k=%0d: got %0b expected %0b", k, cpuEn, expEn); end
            end
            if (k == 7) btnGo = 1'b0;
        end
        expInstr = expInstr + 3;
        turn = 1'b1;
        for (int k = 21; k <= 40; k++) begin
            nextCycle();
            checks++; if (cpuEn !== 1'b1) begin failures++; $display("[TB] FAIL run_fast_en k=%0d: got %0b expected 1", k, cpuEn); end
        end
        expInstr = expInstr + 19;
        checks++; if (instrCnt !== expInstr) begin failures++; $display("[TB] FAIL run_instr_cnt: got %0d expected %0d", instrCnt, expInstr); end
    endtask

    // Halt from fast RUN; HALTED then ignores both buttons.
    task automatic test_halt();
        int bad = 0;
        haltIn = 1'b1;
        nextCycle();
        expInstr = expInstr + 1;
        checks++; if (cpuEn !== 1'b0) begin failures++; $display("[TB] FAIL halt_cpu_en: got %0b expected 0", cpuEn); end
        checks++; if (state !== 2'b11) begin failures++; $display("[TB] FAIL halt_state: got %0d expected 3", state); end
        checks++; if (running !== 1'b0) begin failures++; $display("[TB] FAIL halt_running: got %0b expected 0", running); end
        checks++; if (instrCnt !== expInstr) begin failures++; $display("[TB] FAIL halt_instr_cnt: got %0d expected %0d", instrCnt, expInstr); end
        haltIn = 1'b0;
        for (int k = 0; k < 24; k++) begin
            btnGo   = (k < 8);
            btnStep = (k >= 12 && k < 20);
            nextCycle();
            if (cpuEn !== 1'b0 || state !== 2'b11) bad++;
        end
        btnGo = 1'b0; btnStep = 1'b0;
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL halt_sticky: got %0d bad cycles expected 0", bad); end
        checks++; if (instrCnt !== expInstr) begin failures++; $display("[TB] FAIL halt_instr_hold: got %0d expected %0d", instrCnt, expInstr); end
    endtask

    // Step press in fast RUN pauses to IDLE, beating the coincident tick.
    task automatic test_pause_priority();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        btnGo = 1'b1;
        for (int k = 0; k <= 22; k++) begin
            nextCycle();
            if (k == 6) begin
                checks++; if (state !== 2'b01) begin failures++; $display("[TB] FAIL pause_run_entry: got %0d expected 1", state); end
            end
            if (k == 16) begin
                checks++; if (cpuEn !== 1'b1) begin failures++; $display("[TB] FAIL pause_pre_en: got %0b expected 1", cpuEn); end
            end
            if (k == 17) begin
                checks++; if (state !== 2'b00) begin failures++; $display("[TB] FAIL pause_state: got %0d expected 0", state); end
                checks++; if (cpuEn !== 1'b0) begin failures++; $display("[TB] FAIL pause_cpu_en: got %0b expected 0", cpuEn); end
            end
            if (k == 18) begin
                checks++; if (instrCnt !== 32'd10) begin failures++; $display("[TB] FAIL pause_instr_cnt: got %0d expected 10", instrCnt); end
            end
            if (k == 7) btnGo = 1'b0;
            if (k == 10) btnStep = 1'b1;
            if (k == 20) btnStep = 1'b0;
        end
        checks++; if (state !== 2'b00) begin failures++; $display("[TB] FAIL pause_final: got %0d expected 0", state); end
    endtask

    // Simultaneous presses (go wins), reset mid-RUN, and go held through reset.
    task automatic test_back_to_back();
        nextCycle();
        nextCycle();
        nextCycle();
        btnGo = 1'b1;
        btnStep = 1'b1;
        for (int k = 0; k <= 19; k++) begin
            nextCycle();
            if (k == 5) begin
                checks++; if (state !== 2'b00) begin failures++; $display("[TB] FAIL both_pre_entry: got %0d expected 0", state); end
            end
            if (k == 6) begin
                checks++; if (state !== 2'b01) begin failures++; $display("[TB] FAIL both_go_wins: got %0d expected 1", state); end
            end
            if (k == 9) begin
                checks++; if (cpuEn !== 1'b1) begin failures++; $display("[TB] FAIL both_run_en: got %0b expected 1", cpuEn); end
            end
            if (k == 11) begin
                checks++; if (state !== 2'b00) begin failures++; $display("[TB] FAIL midrst_state: got %0d expected 0", state); end
                checks++; if (cpuEn !== 1'b0) begin failures++; $display("[TB] FAIL midrst_cpu_en: got %0b expected 0", cpuEn); end
                checks++; if (running !== 1'b0) begin failures++; $display("[TB] FAIL midrst_running: got %0b expected 0", running); end
                checks++; if (instrCnt !== 32'd0) begin failures++; $display("[TB] FAIL midrst_instr_cnt: got %0d expected 0", instrCnt); end
            end
            if (k == 12) begin
                checks++; if (cpuEn !== 1'b0) begin failures++; $display("[TB] FAIL midrst_after_en: got %0b expected 0", cpuEn); end
            end
            if (k == 17) begin
                checks++; if (state !== 2'b00) begin failures++; $display("[TB] FAIL held_pre_entry: got %0d expected 0", state); end
            end
            if (k == 18) begin
                checks++; if (state !== 2'b01) begin failures++; $display("[TB] FAIL held_fresh_press: got %0d expected 1", state); end
            end
            if (k == 19) begin
                checks++; if (cpuEn !== 1'b1) begin failures++; $display("[TB] FAIL held_first_en: got %0b expected 1", cpuEn); end
            end
            if (k == 8) btnStep = 1'b0;
            if (k == 10) rst = 1'b1;
            if (k == 11) rst = 1'b0;
        end
        btnGo = 1'b0;
    endtask

    // Instruction counter wraps from all-ones to zero on a single step.
    task automatic test_wrap();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        force dut.instrCnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.instrCnt_q;
        checks++; if (instrCnt !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL wrap_preset: got %0h expected ffffffff", instrCnt); end
        btnStep = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            nextCycle();
            if (k == 7) begin
                checks++; if (cpuEn !== 1'b1) begin failures++; $display("[TB] FAIL wrap_step_en: got %0b expected 1", cpuEn); end
                checks++; if (instrCnt !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL wrap_before: got %0h expected ffffffff", instrCnt); end
            end
            if (k == 8) begin
                checks++; if (instrCnt !== 32'd0) begin failures++; $display("[TB] FAIL wrap_after: got %0h expected 0", instrCnt); end
                btnStep = 1'b0;
            end
        end
        checks++; if (state !== 2'b00) begin failures++; $display("[TB] FAIL wrap_state: got %0d expected 0", state); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_bounce();
        test_run();
        test_halt();
        test_pause_priority();
        test_back_to_back();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Parameters
REQ-001 DEB_CYCLES, 4, consecutive synchronized-high cycles before a button counts as pressed (legal range 1..255).
REQ-002 SLOW_DIV, 4000000, clkN cycles per CPU advance in slow mode (legal range 2..2^26-1).

Interface
REQ-003 clkN  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 btn_go  input  1  raw asynchronous run/resume button.
REQ-006 btn_step  input  1  raw asynchronous single-step/pause button.
REQ-007 turn  input  1  speed select: 1 = fast (advance every cycle), 0 = slow (advance every SLOW_DIV cycles).
REQ-008 halt_in  input  1  halt request decoded from the current instruction (syscall halt).
REQ-009 cpu_en  output  1  PC/regfile/DM write enable; one-cycle-wide pulse per instruction retired.
REQ-010 state  output  2  FSM state: IDLE=00, RUN=01, STEP=10, HALTED=11.
REQ-011 running  output  1  high iff state==RUN.
REQ-012 instr_cnt  output  32  count of cycles with cpu_en=1.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer, then a counter requiring DEB_CYCLES consecutive high samples; any low sample clears the counter.
REQ-014 A debounced press SHALL yield exactly one internal one-cycle pulse (go_p / step_p), regardless of hold duration; a new pulse requires release (one low sample) and a new qualified press.
REQ-015 Pulse latency: the go_p/step_p pulse is asserted in the cycle 2+DEB_CYCLES clkN edges after the first edge that samples the raw input high.
REQ-016 IDLE: cpu_en=0; go_p -> RUN; step_p -> STEP; if both are asserted in the same cycle, go_p wins; halt_in is ignored.
REQ-017 STEP: lasts exactly one cycle; if halt_in=0, cpu_en=1, then -> IDLE; if halt_in=1, cpu_en=0, then -> HALTED.
REQ-018 RUN: a tick counter (26 bits) clears on RUN entry and on any change of turn; tick is asserted every cycle when turn=1, or when counter==SLOW_DIV-1 (counter then wraps to 0) when turn=0.
REQ-019 RUN, tick cycle: halt_in=0 -> cpu_en=1, stay in RUN; halt_in=1 -> cpu_en=0, go to HALTED.
REQ-020 RUN: step_p -> IDLE (pause) with cpu_en=0 in that cycle, taking priority over a coincident tick; go_p is ignored.
REQ-021 With turn=1, the first cpu_en in RUN SHALL occur in the cycle after RUN entry; with turn=0, SLOW_DIV cycles after entry.
REQ-022 HALTED: cpu_en=0; go_p and step_p are ignored; only rst exits.
REQ-023 cpu_en is a registered output and SHALL never be high in two consecutive cycles when turn=0.
REQ-024 instr_cnt SHALL increment by 1 in every cycle with cpu_en=1, wrapping from 32'hFFFFFFFF to 0.
REQ-025 Debounce and synchronizer logic SHALL run in every state, so a press held across a state change produces one pulse only.

Reset
REQ-026 When rst=1 at an edge: state=IDLE, cpu_en=0, running=0, instr_cnt=0, tick counter=0, debounce counters and synchronizers=0, pulses=0.
REQ-027 Reset SHALL override all other inputs, including a mid-RUN tick or a pending pulse; no cpu_en is asserted in the reset cycle or in the following cycle.
REQ-028 A button held through reset release SHALL be treated as a fresh press (it qualifies after 2+DEB_CYCLES cycles).

Verification (DEB_CYCLES=4, SLOW_DIV=4)
REQ-029 Step: rst, then btn_step held high for 10 cycles -> exactly one cpu_en pulse, 7 cycles after the first sampled edge, then state=00, instr_cnt=1.
REQ-030 Bounce: btn_go toggling every 2 cycles for 20 cycles, then low -> no pulse, state stays 00, cpu_en never asserted.
REQ-031 Run: turn=0, go press -> state=01; cpu_en at 4, 8, 12 cycles after entry. Switching turn=1 -> cpu_en every cycle from the next cycle on; after 20 fast cycles instr_cnt equals the count of observed pulses.
REQ-032 Halt: in RUN with turn=1, raise halt_in -> cpu_en=0 in that cycle, state=11 next cycle; subsequent go/step presses leave state=11 and instr_cnt unchanged.
REQ-033 Pause/priority: in RUN, a step press -> state=00 with no cpu_en in the pulse cycle. In IDLE, simultaneous go_p and step_p (both buttons raised on the same edge) -> state=01.
REQ-034 Wrap/reset: force instr_cnt=32'hFFFFFFFF and step once -> instr_cnt=0. Assert rst mid-RUN -> all outputs at reset values in the next cycle, with no cpu_en for 2 cycles.
